// File: rtl/nic_arb_pkg.sv
// Shared types and constants for the NIC master arbiter.
// Slave-select bit positions and region bases of the NIC address map.
package nic_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    localparam int SLAVE_SEL_MSB = 15;
    localparam int SLAVE_SEL_LSB = 14;
    localparam int DEF_RD_LAT = 3;

    localparam logic [15:0] SLV0_BASE = 16'h0000;
    localparam logic [15:0] SLV1_BASE = 16'h4000;
    localparam logic [15:0] SLV2_BASE = 16'h8000;
    localparam logic [15:0] SLV3_BASE = 16'hC000;

endpackage

// File: rtl/nic_master_arbiter_if.sv
// Two-phase sel/enable bus between the arbiter and nic_top's master port.
// The arbiter drives the request side; the NIC returns read data.
interface nic_master_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);

    logic              master_sel;
    logic              master_enable;
    logic              master_wr_dir;
    logic [ADDR_W-1:0] master_addr;
    logic [DATA_W-1:0] master_wdata;
    logic [DATA_W-1:0] master_rdata;

    modport master (
        output master_sel,
        output master_enable,
        output master_wr_dir,
        output master_addr,
        output master_wdata,
        input  master_rdata
    );

    modport slave (
        input  master_sel,
        input  master_enable,
        input  master_wr_dir,
        input  master_addr,
        input  master_wdata,
        output master_rdata
    );

endinterface

// File: rtl/rr_picker.sv
// Round-robin winner selection: first set request at or above ptr, wrapping.
// Purely combinational; the pointer register lives in the parent.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    // Scan upward from ptr and stop at the first asserted request.
    always_comb begin
        int j;
        logic found;
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/nic_master_arbiter.sv
// Round-robin arbiter sharing the single NIC master port among requesters.
// Latches the winner and sequences SETUP/ACCESS/WAIT/DONE on the NIC bus.
module nic_master_arbiter
    import nic_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int RD_LAT  = DEF_RD_LAT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    nic_master_arbiter_if.master      nic
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t              state_q;
    state_t              state_d;
    logic [IW-1:0]       ptr_q;
    logic [IW-1:0]       win_q;
    logic [CW-1:0]       cnt_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IW-1:0]       pick_idx;
    logic                accept;

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    // Next-state decode; a request is taken only while IDLE.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP:  state_d = ACCESS;
            ACCESS: state_d = wr_q ? DONE : WAIT;
            WAIT:   state_d = (cnt_q == '0) ? DONE : WAIT;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant is combinational but must stay low while reset is held.
    assign gnt = (accept && !rst) ? pick_onehot : '0;

    assign nic.master_sel    = (state_q == SETUP) || (state_q == ACCESS) ||
                               (state_q == WAIT);
    assign nic.master_enable = (state_q == ACCESS) || (state_q == WAIT);
    assign nic.master_wr_dir = wr_q;
    assign nic.master_addr   = addr_q;
    assign nic.master_wdata  = wdata_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Latch the winner's request and advance the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            win_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            ptr_q   <= IW'((int'(pick_idx) + 1) % NUM_REQ);
            win_q   <= pick_idx;
            wr_q    <= req_wr[pick_idx];
            addr_q  <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
        end
    end

    // Read-latency counter: loaded on ACCESS, counts down through WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == ACCESS && !wr_q) begin
            cnt_q <= CW'(RD_LAT - 1);
        end else if (state_q == WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Capture read data on the last WAIT edge; pulse done for the winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
            done  <= '0;
        end else begin
            if (state_q == WAIT && cnt_q == '0) rdata <= nic.master_rdata;
            done <= '0;
            if (state_d == DONE) done[win_q] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nic_master_arbiter.sv
// Directed bench for nic_master_arbiter with a NIC/slave memory model.
// Expected completions are queued at grant time and checked at done.
module tb_nic_master_arbiter;
    import nic_arb_pkg::*;

    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = DEF_RD_LAT;

    typedef struct {
        int          idx;
        bit          wr;
        logic [15:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [DW-1:0]   rdata;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   gq[$];
    int   exp_rr[12];

    logic [15:0] slv [0:3][0:16383];
    logic [15:0] p1;
    logic [15:0] p2;

    nic_master_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) nic ();

    nic_master_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .RD_LAT  (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .nic       (nic)
    );

    always #5 clk = ~clk;

    // NIC + slave model: write on ACCESS, read through a 3-deep return pipe.
    always @(posedge clk) begin
        if (nic.master_sel && nic.master_enable && nic.master_wr_dir)
            slv[nic.master_addr[SLAVE_SEL_MSB:SLAVE_SEL_LSB]]
               [nic.master_addr[13:0]] <= nic.master_wdata;
        p1 <= slv[nic.master_addr[SLAVE_SEL_MSB:SLAVE_SEL_LSB]]
                 [nic.master_addr[13:0]];
        p2 <= p1;
        nic.master_rdata <= p2;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input bit wr, input logic [15:0] a,
                         input logic [15:0] d);
        req_wr[i]            = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req[i]               = 1'b1;
    endtask

    // One transaction from a lone requester; d is write data or expected rdata.
    task automatic xact(input int i, input bit wr, input logic [15:0] a,
                        input logic [15:0] d);
        int   cyc;
        bit   ok;
        exp_t e;
        drive(i, wr, a, d);
        #1;
        cyc = 0;
        while (gnt == '0 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("gnt", 32'(gnt), 32'(1 << i));
        sb.push_back('{i, wr, d});
        tick();
        req[i] = 1'b0;
        cyc = 1;
        ok  = 1'b1;
        while (done == '0 && cyc < 40) begin
            if (cyc == 1) begin
                chk("setup", {nic.master_sel, nic.master_enable,
                              nic.master_wr_dir}, {1'b1, 1'b0, wr});
                if (wr) chk("setup_wdata", nic.master_wdata, d);
            end
            if (cyc == 2)
                chk("access", {nic.master_sel, nic.master_enable}, 2'b11);
            if (!(nic.master_sel === 1'b1 && nic.master_addr === a)) ok = 1'b0;
            tick();
            cyc++;
        end
        chk("latency", cyc, wr ? 3 : LAT + 3);
        chk("addr_stable", 32'(ok), 1);
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("done", 32'(done), 32'(1 << e.idx));
            if (!e.wr) chk("rdata", rdata, e.data);
        end
        tick();
    endtask

    initial begin
        int grants;
        int cyc;
        int idx;
        int gcnt;
        int dcnt;
        logic [N-1:0] dor;

        exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 3, 0, 3};
        rst       = 1'b1;
        req       = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_bus", {nic.master_sel, nic.master_enable,
                        nic.master_wr_dir}, 0);
        chk("rst_addr", nic.master_addr, 0);
        chk("rst_wdata", nic.master_wdata, 0);
        rst = 1'b0;
        tick();
        chk("idle_gnt", 32'(gnt), 0);

        // Write then read back through slave 1.
        xact(0, 1'b1, 16'h4005, 16'hBEEF);
        chk("t1_mem", slv[1][5], 16'hBEEF);
        xact(1, 1'b0, 16'h4005, 16'hBEEF);

        // One location per slave, no aliasing.
        xact(0, 1'b1, SLV0_BASE + 16'h0010, 16'h1111);
        xact(1, 1'b1, SLV1_BASE + 16'h0010, 16'h2222);
        xact(2, 1'b1, SLV2_BASE + 16'h0010, 16'h3333);
        xact(3, 1'b1, SLV3_BASE + 16'h0010, 16'h4444);
        xact(1, 1'b0, SLV0_BASE + 16'h0010, 16'h1111);
        xact(2, 1'b0, SLV1_BASE + 16'h0010, 16'h2222);
        xact(3, 1'b0, SLV2_BASE + 16'h0010, 16'h3333);
        xact(0, 1'b0, SLV3_BASE + 16'h0010, 16'h4444);
        xact(2, 1'b1, SLV0_BASE + 16'h0020, 16'h7777);
        chk("rdata_hold", rdata, 16'h4444);

        // Round-robin with all requesters held from reset.
        rst = 1'b1;
        for (int i = 0; i < N; i++)
            drive(i, 1'b1, SLV0_BASE + 16'h0100 + 16'(i), 16'h0A00 + 16'(i));
        tick();
        chk("rst_gnt_forced", 32'(gnt), 0);
        rst = 1'b0;
        #1;
        grants = 0;
        cyc    = 0;
        while ((grants < 12 || gq.size() != 0) && cyc < 400) begin
            if (gnt != '0 && grants < 12) begin
                chk("rr_order", 32'(gnt), 32'(1 << exp_rr[grants]));
                gq.push_back(exp_rr[grants]);
                grants++;
            end
            if (done != '0) begin
                if (gq.size() != 0) begin
                    idx = gq.pop_front();
                    chk("rr_done", 32'(done), 32'(1 << idx));
                end else begin
                    chk("rr_spurious_done", 32'(done), 0);
                end
            end
            tick();
            cyc++;
            if (grants == 7)  req[2:1] = 2'b00;
            if (grants == 12) req = '0;
        end
        chk("rr_count", grants, 12);

        // Reset during the second WAIT cycle of a read.
        drive(2, 1'b0, SLV2_BASE + 16'h0010, 16'h3333);
        #1;
        chk("t5_gnt", 32'(gnt), 32'b0100);
        tick();
        tick();
        tick();
        tick();
        chk("t5_in_wait", {nic.master_sel, nic.master_enable}, 2'b11);
        rst = 1'b1;
        #1;
        chk("t5_bus", {nic.master_sel, nic.master_enable,
                       nic.master_wr_dir}, 0);
        chk("t5_addr", nic.master_addr, 0);
        chk("t5_wdata", nic.master_wdata, 0);
        chk("t5_rdata", rdata, 0);
        chk("t5_gnt_rst", 32'(gnt), 0);
        dcnt = 0;
        for (int k = 0; k < 3; k++) begin
            if (done != '0) dcnt++;
            tick();
        end
        chk("t5_no_done", dcnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        xact(2, 1'b0, SLV2_BASE + 16'h0010, 16'h3333);

        // Requester 1 withdraws while requester 0 is granted.
        drive(0, 1'b1, SLV3_BASE + 16'h0020, 16'h5A5A);
        drive(1, 1'b1, SLV1_BASE + 16'h0020, 16'hA5A5);
        #1;
        chk("t6_gnt", 32'(gnt), 32'b0001);
        tick();
        req  = '0;
        gcnt = 0;
        dcnt = 0;
        dor  = '0;
        for (int k = 0; k < 10; k++) begin
            if (gnt != '0) gcnt++;
            if (done != '0) begin
                dcnt++;
                dor |= done;
            end
            tick();
        end
        chk("t6_no_gnt", gcnt, 0);
        chk("t6_done_cnt", dcnt, 1);
        chk("t6_done_who", 32'(dor), 32'b0001);
        chk("t6_mem", slv[3][16'h20], 16'h5A5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nic_master_arbiter.md
Name: nic_master_arbiter

Overview:
Shares the single NIC master port among NUM_REQ requesters (CPU, DMA, debug, and similar agents) using round-robin arbitration. It latches the winning request and sequences the two-phase sel/enable bus protocol on the NIC master side. For reads, it holds the address through the NIC-plus-slave pipeline and captures master_rdata after a fixed latency. Completion and read data are returned to the winning requester. The block sits directly in front of nic_top's master interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 16, address width; bits [15:14] select the slave, bits [13:0] are the slave-local address
DATA_W, 16, data width
RD_LAT, 3, WAIT cycles after ACCESS before master_rdata is captured (≥1; default matches the NIC register, slave read and NIC return register)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req  in  NUM_REQ  per-requester request valid
req_wr  in  NUM_REQ  per-requester direction, 1 = write
req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i uses slice [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  flattened write data
gnt  out  NUM_REQ  one-hot accept strobe; combinational
done  out  NUM_REQ  one-hot completion pulse; registered
rdata  out  DATA_W  read data, valid while done is nonzero for a read
master_sel  out  1  to NIC
master_enable  out  1  to NIC
master_wr_dir  out  1  to NIC
master_addr  out  ADDR_W  to NIC
master_wdata  out  DATA_W  to NIC
master_rdata  in  DATA_W  from NIC

Behaviour:
- Reset is asynchronous. On reset: state=IDLE, rr_ptr=0, wait counter=0, and all registered outputs are 0 (done, rdata, master_*). gnt=0 because state=IDLE with no valid winner is not guaranteed during reset; gnt is forced 0 while rst=1.
- Reset mid-transaction aborts the transaction. No done is issued. A NIC write already seen by a slave may complete; this is acceptable.
- States: IDLE → SETUP → ACCESS → (WAIT if read) → DONE → IDLE.
- IDLE: master_sel=0, master_enable=0. If any req bit is set, the winner is the first set bit searching upward from rr_ptr, with wrap. In the same cycle: gnt[winner]=1; latch req_wr, req_addr and req_wdata of the winner; set rr_ptr = (winner+1) mod NUM_REQ; go to SETUP. A request is accepted on the edge where req[i]&gnt[i]. After acceptance the requester may drop req or present its next request.
- SETUP, 1 cycle: master_sel=1, master_enable=0, master_wr_dir=latched wr, master_addr and master_wdata from the latched values.
- ACCESS, 1 cycle: master_sel=1, master_enable=1. Write → DONE. Read → WAIT with counter=RD_LAT-1.
- WAIT: sel, enable, wr_dir and addr are held unchanged, because the NIC selects rdata by the current master_addr. The counter decrements each cycle. When the counter reaches 0, master_rdata is captured into rdata at that clock edge and the state goes to DONE.
- DONE, 1 cycle: master_sel=0, master_enable=0, done[winner]=1. rdata holds the captured value; it is unchanged after a write. Next state is IDLE.
- Latency measured from the gnt cycle: a write's done is seen 3 cycles later, a read's done RD_LAT+3 cycles later (6 at the default).
- Occupancy per transaction: a write takes 4 cycles and a read 7 cycles, IDLE included.
- master_addr and master_wdata are never changed outside IDLE→SETUP.
- req changes while a transaction is in flight are ignored until the next IDLE.
- When a single requester asserts req continuously, it is granted every transaction.
- No starvation: with all requesters active, each is granted within NUM_REQ grants.

Decomposition:
- Package nic_arb_pkg holds: the state enum (IDLE, SETUP, ACCESS, WAIT, DONE); SLAVE_SEL_MSB=15 and SLAVE_SEL_LSB=14; the default RD_LAT; the region base constants 0x0000, 0x4000, 0x8000 and 0xC000.
- One sub-module, rr_picker: combinational, taking req and rr_ptr and producing a one-hot winner and its index. The pointer register stays in the parent.

Test Plan:
1. From reset, req0 issues a write to 0x4005 with data 0xBEEF → gnt0 in the same cycle; SETUP shows sel=1, enable=0, wr_dir=1, addr=0x4005; ACCESS shows enable=1; done0 arrives 3 cycles after gnt; slave1 location 0x0005 holds 0xBEEF.
2. req1 issues a read of 0x4005 → master_addr is stable for 5 cycles (SETUP through the last WAIT); done1 arrives 6 cycles after gnt with rdata=0xBEEF.
3. Write 0x1111, 0x2222, 0x3333 and 0x4444 to 0x0010, 0x4010, 0x8010 and 0xC010, then read each back → the matching values are returned with no aliasing between slaves.
4. req[3:0]=1111 held continuously from reset → grant order 0,1,2,3,0,…; then with only req0 and req3 held → order alternates 3,0,3,0 after the pointer wraps.
5. Assert rst during the second WAIT cycle of a read → all master_* outputs and done are 0 immediately with no done pulse; after release, a pending req2 read of 0x8010 completes with 0x3333.
6. A requester drops req in the cycle gnt is asserted for another requester → it receives no gnt and no done; the granted transaction completes normally.
